// File: rtl/uart_receiver.sv
// UART receiver: 16x oversampled 8N1 deframer feeding a show-ahead byte FIFO,
// with sticky framing and overrun flags.
module uart_receiver #(
  parameter int CLOCK_FREQ_HZ = 50000000,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       uart_rx_i,
  input  logic [1:0] baudrate_select_i,
  input  logic       data_read_i,
  input  logic       error_clear_i,
  output logic [7:0] data_o,
  output logic       data_available_o,
  output logic [6:0] data_buffer_level_o,
  output logic       framing_error_o,
  output logic       overrun_error_o
);

  localparam int DIV_9600   = (CLOCK_FREQ_HZ / 153600  > 0) ? CLOCK_FREQ_HZ / 153600  : 1;
  localparam int DIV_19200  = (CLOCK_FREQ_HZ / 307200  > 0) ? CLOCK_FREQ_HZ / 307200  : 1;
  localparam int DIV_57600  = (CLOCK_FREQ_HZ / 921600  > 0) ? CLOCK_FREQ_HZ / 921600  : 1;
  localparam int DIV_115200 = (CLOCK_FREQ_HZ / 1843200 > 0) ? CLOCK_FREQ_HZ / 1843200 : 1;
  localparam int TICK_W     = (DIV_9600 > 1) ? $clog2(DIV_9600) : 1;
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic              rx_meta_q;
  logic              rx_sync_q;
  logic [1:0]        baud_sel_q;
  logic              baud_change;
  logic [TICK_W-1:0] div_m1;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;

  state_t            state_q, state_d;
  logic [3:0]        sample_cnt_q, sample_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              wait_high_q, wait_high_d;
  logic              rx_push;
  logic              frame_err;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [7:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [6:0]        level_q, level_d;
  logic              framing_q, framing_d;
  logic              overrun_q, overrun_d;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              push_ok;
  logic              overrun_set;

  always_comb begin
    div_m1 = TICK_W'(DIV_115200 - 1);
    unique case (baudrate_select_i)
      2'b00:   div_m1 = TICK_W'(DIV_9600 - 1);
      2'b01:   div_m1 = TICK_W'(DIV_19200 - 1);
      2'b10:   div_m1 = TICK_W'(DIV_57600 - 1);
      default: div_m1 = TICK_W'(DIV_115200 - 1);
    endcase
  end

  // A rate change restarts the divider so the new rate starts from a clean phase.
  assign baud_change = (baudrate_select_i != baud_sel_q);
  assign tick        = !baud_change && (tick_cnt_q >= div_m1);

  always_comb begin
    tick_cnt_d = tick_cnt_q + TICK_W'(1);
    if (baud_change || tick) begin
      tick_cnt_d = '0;
    end
  end

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    wait_high_d  = wait_high_q;
    rx_push      = 1'b0;
    frame_err    = 1'b0;
    unique case (state_q)
      IDLE: begin
        sample_cnt_d = '0;
        bit_idx_d    = '0;
        // After a bad stop bit the line must go idle before a new start is accepted.
        if (wait_high_q) begin
          if (rx_sync_q) begin
            wait_high_d = 1'b0;
          end
        end else if (!rx_sync_q) begin
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (sample_cnt_q == 4'd7) begin
            sample_cnt_d = '0;
            bit_idx_d    = '0;
            state_d      = rx_sync_q ? IDLE : DATA;
          end else begin
            sample_cnt_d = sample_cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          sample_cnt_d = sample_cnt_q + 4'd1;
          if (sample_cnt_q == 4'd15) begin
            shift_d   = {rx_sync_q, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_d = STOP;
            end
          end
        end
      end
      STOP: begin
        if (tick) begin
          sample_cnt_d = sample_cnt_q + 4'd1;
          if (sample_cnt_q == 4'd15) begin
            state_d = IDLE;
            if (rx_sync_q) begin
              rx_push = 1'b1;
            end else begin
              frame_err   = 1'b1;
              wait_high_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_full   = (level_q == 7'(FIFO_DEPTH));
  assign fifo_empty  = (level_q == 7'd0);
  assign pop         = data_read_i && !fifo_empty;
  assign push_ok     = rx_push && (!fifo_full || pop);
  assign overrun_set = rx_push && fifo_full && !pop;

  always_comb begin
    mem_d = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = shift_q;
    end
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push_ok && !pop) begin
      level_d = level_q + 7'd1;
    end else if (pop && !push_ok) begin
      level_d = level_q - 7'd1;
    end
  end

  // A new error event in the clearing cycle wins over the clear.
  always_comb begin
    framing_d = frame_err || (framing_q && !error_clear_i);
    overrun_d = overrun_set || (overrun_q && !error_clear_i);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      baud_sel_q   <= baudrate_select_i;
      tick_cnt_q   <= '0;
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      wait_high_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      framing_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_meta_q    <= uart_rx_i;
      rx_sync_q    <= rx_meta_q;
      baud_sel_q   <= baudrate_select_i;
      tick_cnt_q   <= tick_cnt_d;
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      wait_high_q  <= wait_high_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      framing_q    <= framing_d;
      overrun_q    <= overrun_d;
    end
  end

  // Storage carries no reset; the level counter alone defines what is valid.
  always_ff @(posedge clock_i) begin
    mem_q <= mem_d;
  end

  assign data_o              = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign data_available_o    = !fifo_empty;
  assign data_buffer_level_o = level_q;
  assign framing_error_o     = framing_q;
  assign overrun_error_o     = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: frame-level queue model checked every quiet cycle,
// plus hand-computed literal expectations for each scenario.
module tb_uart_receiver;

  localparam int CLK_HZ = 7372800;
  localparam int DEPTH  = 16;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       uart_rx_i;
  logic [1:0] baudrate_select_i;
  logic       data_read_i;
  logic       error_clear_i;
  logic [7:0] data_o;
  logic       data_available_o;
  logic [6:0] data_buffer_level_o;
  logic       framing_error_o;
  logic       overrun_error_o;

  always #5 clock_i = ~clock_i;

  uart_receiver #(
    .CLOCK_FREQ_HZ(CLK_HZ),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock_i            (clock_i),
    .reset_i            (reset_i),
    .uart_rx_i          (uart_rx_i),
    .baudrate_select_i  (baudrate_select_i),
    .data_read_i        (data_read_i),
    .error_clear_i      (error_clear_i),
    .data_o             (data_o),
    .data_available_o   (data_available_o),
    .data_buffer_level_o(data_buffer_level_o),
    .framing_error_o    (framing_error_o),
    .overrun_error_o    (overrun_error_o)
  );

  int         checks = 0;
  int         errors = 0;
  int         cycle = 0;
  bit         check_en = 1'b0;
  logic [7:0] model_q[$];
  bit         model_fe = 1'b0;
  bit         model_oe = 1'b0;
  int         div_cur;
  int         bit_clks;
  int         start_cycle;
  int         rise_cycle = -1;
  int         meas_d;
  logic       prev_avail = 1'b0;
  logic [7:0] popped_at_push = 8'hxx;

  always @(posedge clock_i) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // The model is only a byte queue plus two flags; it is compared whenever no frame is in flight.
  always @(negedge clock_i) begin
    if (check_en) begin
      checkOutput("model_level", 32'(data_buffer_level_o), 32'(model_q.size()));
      checkOutput("model_avail", 32'(data_available_o), (model_q.size() != 0) ? 32'd1 : 32'd0);
      checkOutput("model_data", 32'(data_o), (model_q.size() != 0) ? 32'(model_q[0]) : 32'd0);
      checkOutput("model_framing", 32'(framing_error_o), 32'(model_fe));
      checkOutput("model_overrun", 32'(overrun_error_o), 32'(model_oe));
    end
    if (data_available_o && !prev_avail) rise_cycle = cycle;
    prev_avail = data_available_o;
  end

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic applyStimulus(input logic rx, input logic rd, input logic clr, input logic rst);
    uart_rx_i     = rx;
    data_read_i   = rd;
    error_clear_i = clr;
    reset_i       = rst;
    step();
    data_read_i   = 1'b0;
    error_clear_i = 1'b0;
  endtask

  task automatic pop_byte();
    applyStimulus(uart_rx_i, 1'b1, 1'b0, 1'b0);
    if (model_q.size() != 0) void'(model_q.pop_front());
  endtask

  task automatic clear_errors();
    applyStimulus(uart_rx_i, 1'b0, 1'b1, 1'b0);
    model_fe = 1'b0;
    model_oe = 1'b0;
  endtask

  // act: 0 none, 1 read pulse in the stop-sample cycle, 2 error_clear pulse in that cycle.
  task automatic send_frame(input logic [7:0] b, input int bc, input logic stop_val, input int act);
    while ((cycle % div_cur) != 0) step();
    start_cycle = cycle;
    fork
      begin
        uart_rx_i = 1'b0;
        repeat (bc) step();
        for (int i = 0; i < 8; i++) begin
          uart_rx_i = b[i];
          repeat (bc) step();
        end
        uart_rx_i = stop_val;
        repeat (bc) step();
        uart_rx_i = 1'b1;
        repeat (bc) step();
      end
      begin
        if (act != 0) begin
          while (cycle < start_cycle + meas_d - 1) step();
          if (act == 1) begin
            popped_at_push = data_o;
            data_read_i    = 1'b1;
          end else begin
            error_clear_i = 1'b1;
          end
          step();
          data_read_i   = 1'b0;
          error_clear_i = 1'b0;
        end
      end
    join
  endtask

  task automatic rx_frame(input logic [7:0] b, input int bc, input logic stop_ok, input int act);
    check_en = 1'b0;
    send_frame(b, bc, stop_ok, act);
    if (act == 2) model_oe = 1'b0;
    if (!stop_ok) model_fe = 1'b1;
    else if (model_q.size() < DEPTH) model_q.push_back(b);
    else if (act == 1) begin
      void'(model_q.pop_front());
      model_q.push_back(b);
    end else model_oe = 1'b1;
    check_en = 1'b1;
  endtask

  initial begin
    #10000000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion (cycle %0d)", cycle);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d;
    int nominal;
    int baud;
    uart_rx_i         = 1'b1;
    reset_i           = 1'b1;
    data_read_i       = 1'b0;
    error_clear_i     = 1'b0;
    baudrate_select_i = 2'b11;
    div_cur           = CLK_HZ / (16 * 115200);
    bit_clks          = CLK_HZ / 115200;
    meas_d            = bit_clks * 19 / 2 + 3;
    repeat (3) step();
    reset_i = 1'b0;
    step();
    checkOutput("reset_level", 32'(data_buffer_level_o), 32'd0);
    checkOutput("reset_avail", 32'(data_available_o), 32'd0);
    checkOutput("reset_data", 32'(data_o), 32'h00);
    checkOutput("reset_framing", 32'(framing_error_o), 32'd0);
    checkOutput("reset_overrun", 32'(overrun_error_o), 32'd0);
    check_en = 1'b1;

    $display("[TB] pop while empty");
    pop_byte();
    step();
    checkOutput("empty_pop_level", 32'(data_buffer_level_o), 32'd0);

    $display("[TB] frame 0xA5 at 115200");
    rise_cycle = -1;
    rx_frame(8'hA5, bit_clks, 1'b1, 0);
    d       = rise_cycle - start_cycle;
    nominal = bit_clks * 19 / 2;
    checkOutput("a5_latency_in_window", 32'((d >= nominal - div_cur) && (d <= nominal + div_cur + 4)), 32'd1);
    if ((d >= nominal - div_cur) && (d <= nominal + div_cur + 4)) meas_d = d;
    checkOutput("a5_data", 32'(data_o), 32'hA5);
    checkOutput("a5_level", 32'(data_buffer_level_o), 32'd1);
    pop_byte();
    step();
    checkOutput("a5_pop_level", 32'(data_buffer_level_o), 32'd0);

    $display("[TB] start glitch of 3 ticks");
    uart_rx_i = 1'b0;
    repeat (3 * div_cur) step();
    uart_rx_i = 1'b1;
    repeat (2 * bit_clks) step();
    checkOutput("glitch_level", 32'(data_buffer_level_o), 32'd0);
    checkOutput("glitch_framing", 32'(framing_error_o), 32'd0);

    $display("[TB] framing error and clear");
    rx_frame(8'h3C, bit_clks, 1'b0, 0);
    checkOutput("fe_flag", 32'(framing_error_o), 32'd1);
    checkOutput("fe_level", 32'(data_buffer_level_o), 32'd0);
    clear_errors();
    step();
    checkOutput("fe_cleared", 32'(framing_error_o), 32'd0);
    rx_frame(8'h3C, bit_clks, 1'b0, 2);
    checkOutput("fe_set_wins", 32'(framing_error_o), 32'd1);
    clear_errors();

    $display("[TB] fill 17 frames, no reads");
    for (int i = 0; i < 17; i++) rx_frame(8'(i), bit_clks, 1'b1, 0);
    checkOutput("fill_level", 32'(data_buffer_level_o), 32'd16);
    checkOutput("fill_overrun", 32'(overrun_error_o), 32'd1);
    checkOutput("fill_head", 32'(data_o), 32'h00);
    clear_errors();
    step();
    checkOutput("fill_overrun_cleared", 32'(overrun_error_o), 32'd0);

    $display("[TB] push into full buffer with simultaneous read");
    rx_frame(8'h11, bit_clks, 1'b1, 1);
    checkOutput("full_rw_popped", 32'(popped_at_push), 32'h00);
    checkOutput("full_rw_level", 32'(data_buffer_level_o), 32'd16);
    checkOutput("full_rw_overrun", 32'(overrun_error_o), 32'd0);
    for (int i = 0; i < 16; i++) begin
      checkOutput("pop_order", 32'(data_o), (i < 15) ? 32'(i + 1) : 32'h11);
      pop_byte();
    end
    step();
    checkOutput("drain_level", 32'(data_buffer_level_o), 32'd0);

    $display("[TB] 0x55 at every rate, -2%% and +2%%");
    for (int s = 0; s < 4; s++) begin
      baudrate_select_i = 2'(s);
      baud     = (s == 0) ? 9600 : (s == 1) ? 19200 : (s == 2) ? 57600 : 115200;
      div_cur  = CLK_HZ / (16 * baud);
      bit_clks = CLK_HZ / baud;
      repeat (4) step();
      rx_frame(8'h55, (bit_clks * 98 + 50) / 100, 1'b1, 0);
      rx_frame(8'h55, (bit_clks * 102 + 50) / 100, 1'b1, 0);
    end
    checkOutput("baud_level", 32'(data_buffer_level_o), 32'd8);
    checkOutput("baud_head", 32'(data_o), 32'h55);

    $display("[TB] reset in the middle of a frame");
    rx_frame(8'h0F, bit_clks, 1'b0, 0);
    checkOutput("pre_reset_framing", 32'(framing_error_o), 32'd1);
    check_en = 1'b0;
    while ((cycle % div_cur) != 0) step();
    uart_rx_i = 1'b0;
    repeat (bit_clks) step();
    for (int i = 0; i < 3; i++) begin
      uart_rx_i = (i == 1) ? 1'b1 : 1'b0;
      repeat (bit_clks) step();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    model_q.delete();
    model_fe = 1'b0;
    model_oe = 1'b0;
    checkOutput("midreset_level", 32'(data_buffer_level_o), 32'd0);
    checkOutput("midreset_avail", 32'(data_available_o), 32'd0);
    checkOutput("midreset_data", 32'(data_o), 32'h00);
    checkOutput("midreset_framing", 32'(framing_error_o), 32'd0);
    check_en = 1'b1;
    repeat (2 * bit_clks) step();
    rx_frame(8'h96, bit_clks, 1'b1, 0);
    checkOutput("post_reset_data", 32'(data_o), 32'h96);
    checkOutput("post_reset_level", 32'(data_buffer_level_o), 32'd1);

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
